// File: rtl/gym_move_controller_if.sv
// Movement request / bounds-check / position bus between keyboard decode, bounds checker and controller.
// master = surrounding logic (keyboard decode + bounds checker), slave = gym_move_controller.
interface gym_move_controller_if;
    logic       enable;
    logic       frame_tick;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic       atBounds;
    logic [1:0] direction;
    logic [9:0] charxcurrpos;
    logic [9:0] charycurrpos;
    logic       moving;
    logic       blocked;
    logic       step_done;

    modport master (
        output enable, frame_tick, dir_valid, dir_req, atBounds,
        input  direction, charxcurrpos, charycurrpos, moving, blocked, step_done
    );

    modport slave (
        input  enable, frame_tick, dir_valid, dir_req, atBounds,
        output direction, charxcurrpos, charycurrpos, moving, blocked, step_done
    );
endinterface

// File: rtl/gym_move_controller.sv
// Purpose: one-tile-per-request character mover with bounds check; owns the x/y registers.
// Latency: request->CHECK 1 cycle, CHECK->MOVE/blocked 1 cycle, then STEP_PX per enabled frame_tick.
// Backpressure: requests outside IDLE are dropped unless GYM_MOVE_PENDING_EN keeps the latest one.
module gym_move_controller #(
    parameter int TILE_PX = 32,
    parameter int STEP_PX = 4,
    parameter int START_X = 304,
    parameter int START_Y = 363
) (
    input  logic                  Clk,
    input  logic                  Reset,
    gym_move_controller_if.slave  mv
);
    localparam int NSTEPS = TILE_PX / STEP_PX;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);
    localparam logic [9:0]    STEP = 10'(STEP_PX);

    typedef enum logic [1:0] {IDLE, CHECK, MOVE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [9:0]    px, py;
    logic [9:0]    nx, ny;
    logic [1:0]    dir;
    logic          moving_r, blocked_r, done_r;
    logic          tick_en;
    logic          last_tick;

    assign tick_en   = mv.frame_tick && mv.enable;
    assign last_tick = tick_en && (cnt == LAST);

    // 10-bit wrapping step; walls are the bounds checker's job only
    always_comb begin
        nx = px;
        ny = py;
        case (dir)
            2'd0: ny = py + STEP;
            2'd1: ny = py - STEP;
            2'd2: nx = px - STEP;
            default: nx = px + STEP;
        endcase
    end

`ifdef GYM_MOVE_PENDING_EN
    logic       pend_vld;
    logic [1:0] pend_dir;
    logic       pend_vld_nx;
    logic [1:0] pend_dir_nx;

    // a request arriving in the same cycle wins over the stored one
    assign pend_vld_nx = mv.enable && (mv.dir_valid || pend_vld);
    assign pend_dir_nx = mv.dir_valid ? mv.dir_req : pend_dir;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pend_vld <= 1'b0;
            pend_dir <= 2'd0;
        end else begin
            case (state)
                CHECK: begin
                    pend_vld <= mv.atBounds ? 1'b0 : pend_vld_nx;
                    pend_dir <= pend_dir_nx;
                end
                MOVE: begin
                    pend_vld <= last_tick ? 1'b0 : pend_vld_nx;
                    pend_dir <= pend_dir_nx;
                end
                default: pend_vld <= 1'b0;
            endcase
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            dir       <= 2'd0;
            px        <= 10'(START_X);
            py        <= 10'(START_Y);
            cnt       <= '0;
            moving_r  <= 1'b0;
            blocked_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            blocked_r <= 1'b0;
            done_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (mv.dir_valid && mv.enable) begin
                        dir   <= mv.dir_req;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mv.atBounds) begin
                        blocked_r <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt      <= '0;
                        moving_r <= 1'b1;
                        state    <= MOVE;
                    end
                end
                MOVE: begin
                    if (tick_en) begin
                        px  <= nx;
                        py  <= ny;
                        cnt <= cnt + 1'b1;
                        if (last_tick) begin
                            done_r   <= 1'b1;
                            moving_r <= 1'b0;
                            state    <= IDLE;
`ifdef GYM_MOVE_PENDING_EN
                            if (pend_vld_nx) begin
                                dir   <= pend_dir_nx;
                                state <= CHECK;
                            end
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mv.direction    = dir;
    assign mv.charxcurrpos = px;
    assign mv.charycurrpos = py;
    assign mv.moving       = moving_r;
    assign mv.blocked      = blocked_r;
    assign mv.step_done    = done_r;
endmodule

// File: tb/tb_gym_move_controller.sv
// Randomised + directed bench for gym_move_controller against a tile-level position model.
module tb_gym_move_controller;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    gym_move_controller_if mv ();

    gym_move_controller dut (
        .Clk   (Clk),
        .Reset (Reset),
        .mv    (mv)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ex, ey;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic void adv(input int d);
        case (d)
            0: ey = (ey + 4) % 1024;
            1: ey = (ey + 1020) % 1024;
            2: ex = (ex + 1020) % 1024;
            default: ex = (ex + 4) % 1024;
        endcase
    endfunction

    task automatic check_pos(input string tag);
        chk({tag, "/x"}, 32'(mv.charxcurrpos), ex);
        chk({tag, "/y"}, 32'(mv.charycurrpos), ey);
    endtask

    task automatic do_reset();
        mv.enable     = 1'b1;
        mv.frame_tick = 1'b0;
        mv.dir_valid  = 1'b0;
        mv.dir_req    = 2'd0;
        mv.atBounds   = 1'b0;
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
        ex = 304;
        ey = 363;
    endtask

    // one-cycle request; the bench acts as the bounds checker through blk
    task automatic request(input int d, input bit blk, input string tag);
        mv.atBounds  = blk;
        mv.dir_valid = 1'b1;
        mv.dir_req   = 2'(d);
        step();
        mv.dir_valid = 1'b0;
        chk({tag, "/chk_blk"}, 32'(mv.blocked), 0);
        chk({tag, "/chk_mov"}, 32'(mv.moving), 0);
        step();
        mv.atBounds = 1'b0;
        chk({tag, "/blocked"}, 32'(mv.blocked), 32'(blk));
        chk({tag, "/moving"}, 32'(mv.moving), 32'(!blk));
        chk({tag, "/dir"}, 32'(mv.direction), d);
        check_pos(tag);
    endtask

    // n enabled ticks in direction d, with random frozen (enable=0) ticks and gaps in between
    task automatic move_ticks(input int d, input int n, input bit last_done, input string tag);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(4) == 0) begin
                mv.enable = 1'b0;
                mv.frame_tick = 1'b1;
                step();
                mv.frame_tick = 1'b0;
                mv.enable = 1'b1;
                check_pos({tag, "/frozen"});
            end
            chk({tag, "/mov_pre"}, 32'(mv.moving), 1);
            mv.frame_tick = 1'b1;
            step();
            mv.frame_tick = 1'b0;
            adv(d);
            check_pos(tag);
            chk({tag, "/done"}, 32'(mv.step_done), 32'(last_done && (i == n - 1)));
            if (!(last_done && i == n - 1)) begin
                repeat ($urandom_range(2)) step();
            end
        end
    endtask

    initial begin
        do_reset();
        chk("rst/x", 32'(mv.charxcurrpos), 304);
        chk("rst/y", 32'(mv.charycurrpos), 363);
        chk("rst/dir", 32'(mv.direction), 0);
        chk("rst/moving", 32'(mv.moving), 0);
        chk("rst/blocked", 32'(mv.blocked), 0);
        chk("rst/done", 32'(mv.step_done), 0);
        for (int i = 0; i < 5; i++) begin
            mv.frame_tick = 1'b1;
            step();
            mv.frame_tick = 1'b0;
            step();
            check_pos("idle");
            chk("idle/moving", 32'(mv.moving), 0);
            chk("idle/pulses", 32'({mv.blocked, mv.step_done}), 0);
        end

        // wall below: blocked once, no movement
        request(0, 1'b1, "wall");
        step();
        chk("wall/blk_once", 32'(mv.blocked), 0);
        chk("wall/no_move", 32'(mv.moving), 0);
        chk("wall/y", 32'(mv.charycurrpos), 363);

        // full tile right: 308..336
        request(3, 1'b0, "right");
        move_ticks(3, 8, 1'b1, "right");
        step();
        chk("right/idle_mov", 32'(mv.moving), 0);
        chk("right/x_end", 32'(mv.charxcurrpos), 336);

        // left with a freeze window
        do_reset();
        request(2, 1'b0, "left");
        move_ticks(2, 3, 1'b0, "left");
        chk("left/x292", 32'(mv.charxcurrpos), 292);
        mv.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mv.frame_tick = 1'b1;
            step();
            mv.frame_tick = 1'b0;
            step();
        end
        chk("freeze/x", 32'(mv.charxcurrpos), 292);
        chk("freeze/moving", 32'(mv.moving), 1);
        mv.enable = 1'b1;
        move_ticks(2, 5, 1'b1, "left2");
        chk("left/x272", 32'(mv.charxcurrpos), 272);

        // reset mid-move
        do_reset();
        request(3, 1'b0, "rmid");
        move_ticks(3, 4, 1'b0, "rmid");
        chk("rmid/x320", 32'(mv.charxcurrpos), 320);
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        chk("rmid/x", 32'(mv.charxcurrpos), 304);
        chk("rmid/y", 32'(mv.charycurrpos), 363);
        chk("rmid/moving", 32'(mv.moving), 0);
        ex = 304;
        ey = 363;
        request(0, 1'b0, "after_rst");
        move_ticks(0, 8, 1'b1, "after_rst");

        // request up during a right move
        do_reset();
        request(3, 1'b0, "pend");
        move_ticks(3, 3, 1'b0, "pend");
        mv.dir_valid = 1'b1;
        mv.dir_req   = 2'd1;
        step();
        mv.dir_valid = 1'b0;
        chk("pend/dir_hold", 32'(mv.direction), 3);
        move_ticks(3, 4, 1'b0, "pend");
        mv.frame_tick = 1'b1;
        step();
        mv.frame_tick = 1'b0;
        adv(3);
        chk("pend/done", 32'(mv.step_done), 1);
        check_pos("pend");
`ifdef GYM_MOVE_PENDING_EN
        chk("pend/dir_up", 32'(mv.direction), 1);
        step();
        chk("pend/moving", 32'(mv.moving), 1);
        move_ticks(1, 8, 1'b1, "pend_up");
`else
        chk("pend/dir_right", 32'(mv.direction), 3);
        step();
        chk("pend/no_move", 32'(mv.moving), 0);
        for (int i = 0; i < 3; i++) begin
            mv.frame_tick = 1'b1;
            step();
            mv.frame_tick = 1'b0;
        end
        check_pos("pend_dropped");
`endif
        step();

        // random tiles, biased left so x wraps through 0
        for (int t = 0; t < 40; t++) begin
            int d;
            bit blk;
            if ($urandom_range(5) == 0) begin
                mv.enable    = 1'b0;
                mv.dir_valid = 1'b1;
                mv.dir_req   = 2'($urandom_range(3));
                step();
                mv.dir_valid = 1'b0;
                mv.enable    = 1'b1;
                step();
                chk("rnd_dis/moving", 32'(mv.moving), 0);
                chk("rnd_dis/blocked", 32'(mv.blocked), 0);
                check_pos("rnd_dis");
            end else begin
                d   = ($urandom_range(2) == 0) ? int'($urandom_range(3)) : 2;
                blk = ($urandom_range(3) == 0);
                request(d, blk, "rnd");
                if (!blk) move_ticks(d, 8, 1'b1, "rnd");
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
